// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the RV64 single-port datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// operand selects, writeback select, PC/IR/regfile enables and memory handshake.
// A memory wait longer than TIMEOUT cycles (TIMEOUT=0 disables) traps with cause 2;
// an unknown opcode traps with cause 1.
// Optional: define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt outputs.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        reg_we,
  output logic [1:0]  alu_asel,
  output logic [1:0]  alu_bsel,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef MC_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [1:0]       cause_reg, cause_next;
  logic [1:0]       asel_reg, asel_next;
  logic [1:0]       bsel_reg, bsel_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timed_out;

  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  logic [1:0] dec_asel, dec_bsel;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:7];

  // Opcode classification of the current instruction word (IR after FETCH).
  always_comb begin
    is_r = 1'b0; is_i = 1'b0; is_load = 1'b0; is_store = 1'b0; is_br = 1'b0;
    is_jal = 1'b0; is_jalr = 1'b0; is_lui = 1'b0; is_auipc = 1'b0;
    case (inst[6:0])
      7'b0110011: is_r     = 1'b1;
      7'b0010011: is_i     = 1'b1;
      7'b0000011: is_load  = 1'b1;
      7'b0100011: is_store = 1'b1;
      7'b1100011: is_br    = 1'b1;
      7'b1101111: is_jal   = 1'b1;
      7'b1100111: is_jalr  = 1'b1;
      7'b0110111: is_lui   = 1'b1;
      7'b0010111: is_auipc = 1'b1;
      default: ;
    endcase
    legal = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc;
  end

  // ALU operand selects for the EXEC cycle, derived from the opcode class.
  always_comb begin
    dec_asel = 2'd0;
    dec_bsel = 2'd0;
    if (is_r) begin
      dec_asel = 2'd1; dec_bsel = 2'd1;
    end else if (is_i | is_load | is_store | is_jalr) begin
      dec_asel = 2'd1; dec_bsel = 2'd2;
    end else if (is_auipc | is_jal | is_br) begin
      dec_asel = 2'd2; dec_bsel = 2'd2;
    end else if (is_lui) begin
      dec_asel = 2'd0; dec_bsel = 2'd2;
    end
  end

  // A memory wait has run out when the limit is reached and this cycle brings no ack.
  assign timed_out = (TIMEOUT > 0) && (wait_cnt_reg == TO_LIM) && !mem_ack;

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    state_next   = state_reg;
    cause_next   = cause_reg;
    asel_next    = asel_reg;
    bsel_next    = bsel_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    reg_we       = 1'b0;
    alu_asel     = 2'd0;
    alu_bsel     = 2'd0;
    wb_sel       = 2'd0;
    trap         = 1'b0;
    trap_cause   = cause_reg;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          cause_next = 2'd1;
        end
      end
      S_EXEC: begin
        alu_asel  = dec_asel;
        alu_bsel  = dec_bsel;
        asel_next = dec_asel;
        bsel_next = dec_bsel;
        if (is_br) begin
          pc_we      = 1'b1;
          pc_sel     = br_taken;
          state_next = S_FETCH;
        end else if (is_load | is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        alu_asel     = asel_reg;
        alu_bsel     = bsel_reg;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = 2'd2;
        end
      end
      S_WB: begin
        alu_asel   = asel_reg;
        alu_bsel   = bsel_reg;
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = is_jal | is_jalr;
        wb_sel     = is_load ? 2'd2 : ((is_jal | is_jalr) ? 2'd3 : 2'd1);
        state_next = S_FETCH;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_next = S_TRAP;
        cause_next = 2'd1;
      end
    endcase
    if (rst) begin
      mem_req = 1'b0; mem_we = 1'b0; mem_addr_sel = 1'b0; ir_we = 1'b0;
      pc_we = 1'b0; pc_sel = 1'b0; reg_we = 1'b0; alu_asel = 2'd0;
      alu_bsel = 2'd0; wb_sel = 2'd0; trap = 1'b0; trap_cause = 2'd0;
    end
  end

  // State, trap cause, held operand selects and the memory wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      cause_reg    <= 2'd0;
      asel_reg     <= 2'd0;
      bsel_reg     <= 2'd0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      asel_reg  <= asel_next;
      bsel_reg  <= bsel_next;
      if (state_next != state_reg || mem_ack || !mem_req)
        wait_cnt_reg <= '0;
      else
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [63:0] cycle_cnt_reg, instret_cnt_reg;

  // Cycle count (frozen while trapped) and retired-instruction count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_reg != S_TRAP)
        cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      if (state_next == S_FETCH &&
          (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB))
        instret_cnt_reg <= instret_cnt_reg + 64'd1;
    end
  end

  assign cycle_cnt   = rst ? 64'd0 : cycle_cnt_reg;
  assign instret_cnt = rst ? 64'd0 : instret_cnt_reg;
`endif

endmodule
